// File: rtl/score_bcd_scanner_if.sv
// Score/display bundle between collision logic, snake body logic and the
// seven-segment bank.
interface score_bcd_scanner_if #(
    parameter int NUM_DIGITS = 3,
    parameter int LEN_W      = 10
) ();
    logic                    goodColl;
    logic                    badColl;
    logic                    clearHigh;
    logic [LEN_W-1:0]        length;
    logic                    isGameComplete;
    logic [4*NUM_DIGITS-1:0] bcd_score;
    logic [4*NUM_DIGITS-1:0] bcd_high;
    logic [NUM_DIGITS-1:0]   digit_sel;
    logic [6:0]              seg;

    modport master (
        output goodColl, badColl, clearHigh,
        input  length, isGameComplete, bcd_score, bcd_high,
        input  digit_sel, seg
    );

    modport slave (
        input  goodColl, badColl, clearHigh,
        output length, isGameComplete, bcd_score, bcd_high,
        output digit_sel, seg
    );
endinterface

// File: rtl/score_bcd_scanner.sv
// BCD score / high-score tracker with PLAY/OVER game state and a
// time-multiplexed, leading-zero-blanked seven-segment display.
module score_bcd_scanner #(
    parameter int NUM_DIGITS = 3,
    parameter int MAX_SCORE  = 999,
    parameter int SCAN_DIV   = 1000,
    parameter int LEN_W      = 10
) (
    input  logic               clk,
    input  logic               nRst,
    score_bcd_scanner_if.slave bus
);
    localparam int BW    = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic {PLAY, OVER} state_t;

    state_t           state;
    logic [LEN_W-1:0] score_bin;
    logic [BW-1:0]    score_bcd;
    logic [BW-1:0]    high_bcd;
    logic [BW-1:0]    nxt_bcd;
    logic [BW-1:0]    disp;
    logic [BW-1:0]    shv;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic [NUM_DIGITS-1:0] sel;
    logic [6:0]       seg_q;
    logic [6:0]       seg_d;
    logic             at_max;

    function automatic logic [BW-1:0] bcd_inc(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        logic          c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (c) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b0111111;
            4'd1:    return 7'b0000110;
            4'd2:    return 7'b1011011;
            4'd3:    return 7'b1001111;
            4'd4:    return 7'b1100110;
            4'd5:    return 7'b1101101;
            4'd6:    return 7'b1111101;
            4'd7:    return 7'b0000111;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1100111;
            default: return 7'b0000000;
        endcase
    endfunction

    assign nxt_bcd = bcd_inc(score_bcd);
    assign at_max  = (score_bin + LEN_W'(1)) == LEN_W'(MAX_SCORE);
    assign disp    = (state == OVER) ? high_bcd : score_bcd;
    // Shifting the selected digit to the bottom leaves it plus every
    // higher digit, so one zero test covers leading-zero blanking.
    assign shv     = disp >> {idx, 2'b00};

    always_comb begin
        seg_d = seg7(shv[3:0]);
        if (idx != '0 && shv == '0) seg_d = 7'b0000000;
    end

    always_ff @(posedge clk) begin
        if (!nRst) begin
            state     <= PLAY;
            score_bin <= '0;
            score_bcd <= '0;
            high_bcd  <= '0;
            cnt       <= '0;
            idx       <= '0;
            sel       <= NUM_DIGITS'(1);
            seg_q     <= 7'b0111111;
        end else begin
            case (state)
                PLAY: begin
                    if (bus.badColl) begin
                        state <= OVER;
                    end else if (bus.goodColl) begin
                        score_bin <= score_bin + LEN_W'(1);
                        score_bcd <= nxt_bcd;
                        if (nxt_bcd > high_bcd) high_bcd <= nxt_bcd;
                        if (at_max) state <= OVER;
                    end
                end
                OVER: begin
                    if (bus.goodColl) begin
                        state     <= PLAY;
                        score_bin <= LEN_W'(1);
                        score_bcd <= BW'(1);
                        if (bus.clearHigh || high_bcd == '0)
                            high_bcd <= BW'(1);
                    end else if (bus.clearHigh) begin
                        high_bcd <= '0;
                    end
                end
                default: state <= PLAY;
            endcase

            if (cnt == CNT_W'(SCAN_DIV - 1)) begin
                cnt <= '0;
                if (idx == IDX_W'(NUM_DIGITS - 1)) idx <= '0;
                else idx <= idx + IDX_W'(1);
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            sel   <= NUM_DIGITS'(1) << idx;
            seg_q <= seg_d;
        end
    end

    assign bus.length         = score_bin;
    assign bus.isGameComplete = (state == OVER);
    assign bus.bcd_score      = score_bcd;
    assign bus.bcd_high       = high_bcd;
    assign bus.digit_sel      = sel;
    assign bus.seg            = seg_q;
endmodule
